// File: rtl/knn_local_sp_stager_pkg.sv
// Shared definitions for the partialKnn local search-space stager.
//   state_e     : stager FSM states
//   MODE_LOAD   : cmd_mode value selecting a buffer load from the input stream
//   MODE_STREAM : cmd_mode value selecting a buffer read-out to the output stream
package knn_stager_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic MODE_LOAD   = 1'b0;
  localparam logic MODE_STREAM = 1'b1;

endpackage

// File: rtl/knn_local_sp_stager_if.sv
// Bus bundle between the stager and its environment.
//   cmd_*  : command request (valid/ready), mode and word count, done pulse
//   in_*   : 256-bit load stream into the stager (valid/ready)
//   out_*  : 256-bit read-out stream towards distance compute (valid/ready/last)
//   mem_*  : single-port URAM buffer port owned by the stager
// slave  : the stager side
// master : the environment side (command source, stream endpoints, buffer)
interface knn_local_sp_stager_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 11
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_mode;
  logic [ADDR_W:0]   cmd_len;
  logic              done;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  logic [ADDR_W-1:0] mem_address0;
  logic              mem_ce0;
  logic              mem_we0;
  logic [DATA_W-1:0] mem_d0;
  logic [DATA_W-1:0] mem_q0;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_len, in_data, in_valid, out_ready, mem_q0,
    output cmd_ready, done, in_ready, out_data, out_valid, out_last,
           mem_address0, mem_ce0, mem_we0, mem_d0
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_len, in_data, in_valid, out_ready, mem_q0,
    input  cmd_ready, done, in_ready, out_data, out_valid, out_last,
           mem_address0, mem_ce0, mem_we0, mem_d0
  );

endinterface

// File: rtl/knn_local_sp_stager_ofifo.sv
// Register FIFO that absorbs buffer read data while the output stream is
// backpressured. Each entry carries a word plus its end-of-command flag.
//   push_i/push_data_i/push_last_i : write side
//   pop_i                          : consume head (ignored when empty)
//   head_data_o/head_last_o        : current head entry
//   count_o/full_o/empty_o         : occupancy
module knn_stager_ofifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            push_data_i,
  input  logic                         push_last_i,
  input  logic                         pop_i,
  output logic [DATA_W-1:0]            head_data_o,
  output logic                         head_last_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W:0]  slot_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  // A pop frees the head slot in the same cycle, so a push at full is legal
  // when paired with a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) slot_q[wr_ptr_q] <= {push_last_i, push_data_i};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign {head_last_o, head_data_o} = slot_q[rd_ptr_q];

endmodule

// File: rtl/knn_local_sp_stager.sv
// Stager for one partialKnn local search-space buffer (single-port URAM).
// LOAD writes cmd_len incoming words to addresses 0..len-1; STREAM reads them
// back in order and emits them downstream. Read latency is hidden behind a
// small output FIFO whose free space is handed out as read credits.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : command, load stream, output stream and buffer port
module knn_local_sp_stager
  import knn_stager_pkg::*;
#(
  parameter int DATA_W     = 256,
  parameter int ADDR_RANGE = 2048,
  parameter int ADDR_W     = 11,
  parameter int RD_LAT     = 2,
  parameter int OFIFO_D    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  knn_local_sp_stager_if.slave  bus
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int FCNT_W = $clog2(OFIFO_D+1);
  localparam int OCC_W  = FCNT_W + 1;

  state_e             state_q;
  logic               cmd_ready_q, in_ready_q, done_q;
  logic [CNT_W-1:0]   len_q, wr_cnt_q, rd_cnt_q;
  logic [RD_LAT-1:0]  vld_sr_q, last_sr_q;

  logic               wr_fire, rd_issue, rd_last;
  logic [OCC_W-1:0]   inflight, occ;
  logic [FCNT_W-1:0]  fifo_count;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W-1:0]  fifo_data;
  logic               fifo_last;
  logic [CNT_W-1:0]   len_clamped;

  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] l);
    return (l > CNT_W'(ADDR_RANGE)) ? CNT_W'(ADDR_RANGE) : l;
  endfunction

  assign len_clamped = clamp_len(bus.cmd_len);

  // Outstanding words = buffered + still in the read pipeline; a read is only
  // issued while that total is below the FIFO depth, so capture can never
  // find the FIFO full.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OCC_W'(vld_sr_q[i]);
    occ = OCC_W'(fifo_count) + inflight;
  end

  assign wr_fire  = (state_q == LOAD) && bus.in_valid;
  assign rd_issue = (state_q == STREAM) && (rd_cnt_q < len_q) && (occ < OCC_W'(OFIFO_D));
  assign rd_last  = (rd_cnt_q == len_q - CNT_W'(1));

  // Buffer port: load writes go straight through combinationally.
  always_comb begin
    bus.mem_ce0      = 1'b0;
    bus.mem_we0      = 1'b0;
    bus.mem_address0 = '0;
    if (wr_fire) begin
      bus.mem_ce0      = 1'b1;
      bus.mem_we0      = 1'b1;
      bus.mem_address0 = wr_cnt_q[ADDR_W-1:0];
    end else if (rd_issue) begin
      bus.mem_ce0      = 1'b1;
      bus.mem_address0 = rd_cnt_q[ADDR_W-1:0];
    end
  end
  assign bus.mem_d0 = bus.in_data;

  // Read pipeline: tracks which cycles carry valid q0 data and which word ends the command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_sr_q  <= '0;
      last_sr_q <= '0;
    end else begin
      vld_sr_q[0]  <= rd_issue;
      last_sr_q[0] <= rd_issue && rd_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr_q[i]  <= vld_sr_q[i-1];
        last_sr_q[i] <= last_sr_q[i-1];
      end
    end
  end

  // Capture stage: q0 enters the FIFO RD_LAT cycles after issue.
  assign fifo_pop = bus.out_ready && !fifo_empty;

  knn_stager_ofifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OFIFO_D)
  ) u_ofifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (vld_sr_q[RD_LAT-1]),
    .push_data_i (bus.mem_q0),
    .push_last_i (last_sr_q[RD_LAT-1]),
    .pop_i       (fifo_pop),
    .head_data_o (fifo_data),
    .head_last_o (fifo_last),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_data;
  assign bus.out_last  = fifo_last && !fifo_empty;

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      len_q       <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            len_q       <= len_clamped;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            cmd_ready_q <= 1'b0;
            if (len_clamped == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (bus.cmd_mode == MODE_LOAD) begin
              state_q    <= LOAD;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= STREAM;
            end
          end
        end
        LOAD: begin
          if (wr_fire) begin
            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            if (wr_cnt_q + CNT_W'(1) == len_q) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (rd_issue) begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            if (rd_last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && (inflight == '0)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_knn_local_sp_stager.sv
// Randomized bench for knn_local_sp_stager paired with a RD_LAT=2 URAM model.
// The reference is simply the list of words the bench itself loaded: a STREAM
// of n words must return ref_mem[0..n-1] in order with last on the final one.
module tb_knn_local_sp_stager;
  import knn_stager_pkg::*;

  localparam int DW = 256;
  localparam int DEPTH = 2048;
  localparam int FIFO_D = 4;

  logic clk, reset_n;
  knn_local_sp_stager_if #(.DATA_W(DW), .ADDR_W(11)) bus ();

  knn_local_sp_stager dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // URAM: registered read with one extra output register (two cycles ce0 -> q0).
  logic [DW-1:0] uram [DEPTH];
  logic [DW-1:0] rd1, q0;
  always @(posedge clk) begin
    if (bus.mem_ce0 && bus.mem_we0)  uram[bus.mem_address0] <= bus.mem_d0;
    if (bus.mem_ce0 && !bus.mem_we0) rd1 <= uram[bus.mem_address0];
    q0 <= rd1;
  end
  assign bus.mem_q0 = q0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW:0]   outq [$];
  int n_chk, n_err;
  int cyc, acc_cyc, first_ov, done_cyc;
  int n_wr, n_rd, n_ce, n_done, wr_bad, rd_bad, wr_idx, rd_idx, popped, max_occ;
  logic in_acc;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: observe settled signals, log the handshakes of the coming edge.
  task automatic cycle();
    #1;
    in_acc = bus.in_valid && bus.in_ready;
    if (bus.mem_ce0) n_ce++;
    if (bus.mem_ce0 && bus.mem_we0) begin
      n_wr++;
      if (bus.mem_address0 !== 11'(wr_idx) || bus.mem_d0 !== bus.in_data || !in_acc) wr_bad++;
      wr_idx++;
    end
    if (bus.mem_ce0 && !bus.mem_we0) begin
      n_rd++;
      if (bus.mem_address0 !== 11'(rd_idx)) rd_bad++;
      rd_idx++;
      if (rd_idx - popped > max_occ) max_occ = rd_idx - popped;
    end
    if (bus.out_valid && first_ov < 0) first_ov = cyc;
    if (bus.out_valid && bus.out_ready) begin
      outq.push_back({bus.out_last, bus.out_data});
      popped++;
    end
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue_cmd(input logic mode, input int len);
    n_wr = 0; n_rd = 0; n_ce = 0; n_done = 0; wr_bad = 0; rd_bad = 0;
    wr_idx = 0; rd_idx = 0; popped = 0; max_occ = 0; first_ov = -1; done_cyc = -1;
    outq.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = mode;
    bus.cmd_len   = 12'(len);
    #1;
    chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
    acc_cyc = cyc;
    cycle();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int b;
    b = 0;
    while (n_done == 0 && b < budget) begin
      cycle();
      b++;
    end
  endtask

  task automatic run_load(input int len, input int pct);
    int effl, k, last_c, b;
    logic [DW-1:0] w;
    effl = (len > DEPTH) ? DEPTH : len;
    issue_cmd(MODE_LOAD, len);
    k = 0; b = 0; last_c = -100;
    while (k < effl && b < 20*effl + 100) begin
      w = rand256();
      bus.in_valid = ($urandom_range(99) < pct);
      bus.in_data  = w;
      cycle();
      b++;
      if (in_acc) begin
        ref_mem[k] = w;
        k++;
        last_c = cyc - 1;
      end
    end
    bus.in_valid = 1'b0;
    wait_done(8);
    chk("load_words", k, effl);
    chk("load_wr_strobes", n_wr, effl);
    chk("load_wr_addr_data", wr_bad, 0);
    chk("load_done_count", n_done, 1);
    chk("load_done_lat", done_cyc - last_c, 1);
    if (pct == 100) chk("load_cycles", last_c - acc_cyc, effl);
  endtask

  task automatic run_stream(input int len, input int pct, input int hold, input bit chk_lat);
    int effl, b, bad;
    effl = (len > DEPTH) ? DEPTH : len;
    issue_cmd(MODE_STREAM, len);
    b = 0;
    while (n_done == 0 && b < 40*effl + 200) begin
      if (hold > 0 && b == hold)
        chk("hold_reads", n_rd, (effl < FIFO_D) ? effl : FIFO_D);
      bus.out_ready = (b < hold) ? 1'b0 : ($urandom_range(99) < pct);
      cycle();
      b++;
    end
    #1;
    chk("strm_idle_valid", bus.out_valid, 1'b0);
    chk("strm_done_count", n_done, 1);
    chk("strm_words", outq.size(), effl);
    bad = 0;
    foreach (outq[i]) if (outq[i] !== {(i == effl-1), ref_mem[i]}) bad++;
    chk("strm_data_last", bad, 0);
    chk("strm_reads", n_rd, effl);
    chk("strm_read_addr", rd_bad, 0);
    chk("strm_outstanding_le4", (max_occ <= FIFO_D), 1'b1);
    if (chk_lat) chk("strm_first_valid_lat", first_ov - acc_cyc - 1, 3);
    @(negedge clk);
  endtask

  task automatic run_zero(input logic mode);
    issue_cmd(mode, 0);
    wait_done(8);
    chk("zero_done_lat", done_cyc - acc_cyc, 1);
    chk("zero_no_ce", n_ce, 0);
  endtask

  initial begin
    int b, nd;
    n_chk = 0; n_err = 0; cyc = 0;
    n_done = 0; first_ov = -1; done_cyc = -1;
    bus.cmd_valid = 1'b0; bus.cmd_mode = 1'b0; bus.cmd_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_ce0", bus.mem_ce0, 1'b0);
    chk("rst_we0", bus.mem_we0, 1'b0);
    chk("rst_addr0", bus.mem_address0, 0);
    @(negedge clk);

    run_load(16, 100);
    run_stream(16, 100, 0, 1'b1);
    run_load(2048, 70);
    run_stream(2048, 30, 0, 1'b0);
    run_stream(8, 100, 50, 1'b0);
    run_zero(MODE_LOAD);
    run_zero(MODE_STREAM);
    run_stream(3000, 100, 0, 1'b0);

    // Abort a STREAM after five words have left.
    issue_cmd(MODE_STREAM, 16);
    bus.out_ready = 1'b1;
    b = 0;
    while (outq.size() < 5 && b < 100) begin
      cycle();
      b++;
    end
    chk("abort_reached_word5", outq.size(), 5);
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_ce0", bus.mem_ce0, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    nd = n_done;
    @(negedge clk);
    repeat (2) cycle();
    reset_n = 1'b1;
    #1;
    chk("abort_cmd_ready", bus.cmd_ready, 1'b1);
    @(negedge clk);
    repeat (3) cycle();
    chk("abort_no_done", n_done, nd);

    run_load(16, 100);
    run_stream(16, 100, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
